mem_port_arbiter: RTL

Two-requester arbiter and sequencer in front of the single-port 256×32 main memory. It shares the memory between the instruction-fetch port (read-only) and the load/store port (read/write, byte-masked). It issues exactly one memory request per transaction and times the registered read return. It also returns read data and completion pulses to the winning requester. Load/store has priority, with a starvation guard for fetch.

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Fetch / load-store arbiter and sequencer for the single-port 256x32 memory.
// Rev    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [7:0]  dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_mask,
    output logic        dm_gnt,
    output logic        dm_done,
    output logic [31:0] dm_rdata,
    output logic        mem_request,
    output logic        mem_re_we,
    output logic [7:0]  mem_address,
    output logic [31:0] mem_data_in,
    output logic [3:0]  mem_mask,
    input  logic        mem_valid,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    state_t      r_state, w_state_nxt;
    logic        r_sel_if, w_sel_if_nxt;
    logic        r_we, w_we_nxt;
    logic [3:0]  r_starve_cnt, w_starve_cnt_nxt;
    logic        w_win_if;
    logic        w_if_gnt_nxt, w_dm_gnt_nxt, w_if_done_nxt, w_dm_done_nxt;
    logic [31:0] w_if_rdata_nxt, w_dm_rdata_nxt;
    logic        w_mem_request_nxt, w_mem_re_we_nxt;
    logic [7:0]  w_mem_address_nxt;
    logic [31:0] w_mem_data_in_nxt;
    logic [3:0]  w_mem_mask_nxt;

    always_comb begin
        w_state_nxt       = r_state;
        w_sel_if_nxt      = r_sel_if;
        w_we_nxt          = r_we;
        w_starve_cnt_nxt  = r_starve_cnt;
        w_if_gnt_nxt      = 1'b0;
        w_dm_gnt_nxt      = 1'b0;
        w_if_done_nxt     = 1'b0;
        w_dm_done_nxt     = 1'b0;
        w_if_rdata_nxt    = if_rdata;
        w_dm_rdata_nxt    = dm_rdata;
        w_mem_request_nxt = 1'b0;
        w_mem_re_we_nxt   = 1'b0;
        w_mem_address_nxt = mem_address;
        w_mem_data_in_nxt = mem_data_in;
        w_mem_mask_nxt    = mem_mask;
        // Fetch wins when load/store is idle or has starved it long enough.
        w_win_if = !dm_req || (if_req && (r_starve_cnt == c_starve_limit));

        case (r_state)
            IDLE: begin
                if (if_req || dm_req) begin
                    w_state_nxt       = ISSUE;
                    w_sel_if_nxt      = w_win_if;
                    w_mem_request_nxt = 1'b1;
                    if (w_win_if) begin
                        w_we_nxt          = 1'b0;
                        w_mem_address_nxt = if_addr;
                        w_mem_data_in_nxt = 32'd0;
                        w_mem_mask_nxt    = 4'd0;
                        w_if_gnt_nxt      = 1'b1;
                        w_starve_cnt_nxt  = 4'd0;
                    end else begin
                        w_we_nxt          = dm_we;
                        w_mem_re_we_nxt   = dm_we;
                        w_mem_address_nxt = dm_addr;
                        w_mem_data_in_nxt = dm_wdata;
                        w_mem_mask_nxt    = dm_mask;
                        w_dm_gnt_nxt      = 1'b1;
                        if (!if_req)
                            w_starve_cnt_nxt = 4'd0;
                        else if (r_starve_cnt < c_starve_limit)
                            w_starve_cnt_nxt = r_starve_cnt + 4'd1;
                    end
                end
            end
            ISSUE: begin
                // Only load/store can write, so a write always completes on dm.
                if (r_we) begin
                    w_state_nxt   = RESP;
                    w_dm_done_nxt = 1'b1;
                end else begin
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (mem_valid) begin
                    w_state_nxt = RESP;
                    if (r_sel_if) begin
                        w_if_rdata_nxt = mem_data_out;
                        w_if_done_nxt  = 1'b1;
                    end else begin
                        w_dm_rdata_nxt = mem_data_out;
                        w_dm_done_nxt  = 1'b1;
                    end
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sel_if     <= 1'b0;
            r_we         <= 1'b0;
            r_starve_cnt <= 4'd0;
            if_gnt       <= 1'b0;
            dm_gnt       <= 1'b0;
            if_done      <= 1'b0;
            dm_done      <= 1'b0;
            if_rdata     <= 32'd0;
            dm_rdata     <= 32'd0;
            mem_request  <= 1'b0;
            mem_re_we    <= 1'b0;
            mem_address  <= 8'd0;
            mem_data_in  <= 32'd0;
            mem_mask     <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel_if     <= w_sel_if_nxt;
            r_we         <= w_we_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
            if_gnt       <= w_if_gnt_nxt;
            dm_gnt       <= w_dm_gnt_nxt;
            if_done      <= w_if_done_nxt;
            dm_done      <= w_dm_done_nxt;
            if_rdata     <= w_if_rdata_nxt;
            dm_rdata     <= w_dm_rdata_nxt;
            mem_request  <= w_mem_request_nxt;
            mem_re_we    <= w_mem_re_we_nxt;
            mem_address  <= w_mem_address_nxt;
            mem_data_in  <= w_mem_data_in_nxt;
            mem_mask     <= w_mem_mask_nxt;
        end
    end

endmodule
`default_nettype wire
